// File: rtl/link_pkg.sv
// Shared definitions for the peer-board link receiver.
// Provides:
//   link_state_t        - receiver FSM states
//   RES_* codes         - meaning of the 2-bit peer result bus
//   *_DEFAULT constants - default filter length and timeout
//   is_capture_code()   - true for result codes that get latched
package link_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PEER_READY = 2'd1,
    GOT        = 2'd2,
    ERROR      = 2'd3
  } link_state_t;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_OK      = 2'b01;
  localparam logic [1:0] RES_WRONG   = 2'b10;
  localparam logic [1:0] RES_ILLEGAL = 2'b11;

  localparam int STABLE_CYC_DEFAULT  = 16;
  localparam int TIMEOUT_CYC_DEFAULT = 50_000_000;

  // Only "correct" and "wrong" are real answers from the peer.
  function automatic logic is_capture_code(input logic [1:0] code);
    return (code == RES_OK) || (code == RES_WRONG);
  endfunction

endpackage

// File: rtl/link_rx_sync_filter.sv
// Two-flop synchronizer followed by a stability filter for a WIDTH-bit
// asynchronous word. The filtered output only takes a new value after the
// synchronized word has held that value for STABLE_CYC consecutive cycles,
// which is STABLE_CYC+2 cycles after the raw change. Any change of the
// synchronized word before then restarts the count.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   raw      - asynchronous input word
//   filtered - synchronized, debounced word
module sync_filter #(
  parameter int WIDTH      = 1,
  parameter int STABLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] filtered
);

  localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_q;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_base;

  // A fresh change of the synchronized word counts as the first stable
  // cycle, so the count restarts from zero rather than continuing.
  always_comb begin
    cnt_base = (sync != sync_q) ? {CW{1'b0}} : cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= '0;
      sync     <= '0;
      sync_q   <= '0;
      cnt      <= '0;
      filtered <= '0;
    end else begin
      meta   <= raw;
      sync   <= meta;
      sync_q <= sync;
      if (sync == filtered) begin
        cnt <= '0;
      end else if (cnt_base == CNT_LAST) begin
        filtered <= sync;
        cnt      <= '0;
      end else begin
        cnt <= cnt_base + CW'(1);
      end
    end
  end

endmodule

// File: rtl/link_rx.sv
// Receiver for the GPIO handshake with a peer board. The peer raises a
// ready line, then drives a 2-bit result code. Both inputs are
// synchronized and debounced, then a small FSM captures the result,
// flags illegal codes and times out if the peer never answers.
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset
//   ready_in     - raw peer ready line (asynchronous)
//   result_in    - raw peer result bus (asynchronous)
//   clr          - one-cycle pulse clearing a sticky error
//   ready_2p     - filtered peer ready level
//   ready_rise   - one-cycle pulse when the peer becomes ready
//   result       - last captured result, held
//   result_valid - one-cycle pulse when result is updated
//   link_err     - sticky, illegal result code received
//   timeout      - sticky, peer gave no result in time
module link_rx
  import link_pkg::*;
#(
  parameter int STABLE_CYC  = STABLE_CYC_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready_in,
  input  logic [1:0] result_in,
  input  logic       clr,
  output logic       ready_2p,
  output logic       ready_rise,
  output logic [1:0] result,
  output logic       result_valid,
  output logic       link_err,
  output logic       timeout
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  link_state_t state;
  link_state_t state_next;

  logic          ready_f;
  logic          ready_f_q;
  logic [1:0]    result_f;
  logic [TW-1:0] tcnt;

  logic          rise_next;
  logic          valid_next;
  logic [1:0]    result_next;
  logic          link_err_next;
  logic          timeout_next;

  sync_filter #(
    .WIDTH     (1),
    .STABLE_CYC(STABLE_CYC)
  ) u_ready_filter (
    .clk     (clk),
    .rst     (rst),
    .raw     (ready_in),
    .filtered(ready_f)
  );

  // The result bus is filtered as one word so a skewed two-bit transition
  // can never be seen as an intermediate code.
  sync_filter #(
    .WIDTH     (2),
    .STABLE_CYC(STABLE_CYC)
  ) u_result_filter (
    .clk     (clk),
    .rst     (rst),
    .raw     (result_in),
    .filtered(result_f)
  );

  // Next-state and next-output logic. A valid result is checked before a
  // falling ready so a result arriving together with the ready drop is
  // still captured.
  always_comb begin
    state_next    = state;
    rise_next     = 1'b0;
    valid_next    = 1'b0;
    result_next   = result;
    link_err_next = link_err;
    timeout_next  = timeout;
    case (state)
      IDLE: begin
        if (ready_f && !ready_f_q) begin
          state_next = PEER_READY;
          rise_next  = 1'b1;
        end
      end
      PEER_READY: begin
        if (is_capture_code(result_f)) begin
          state_next  = GOT;
          result_next = result_f;
          valid_next  = 1'b1;
        end else if (result_f == RES_ILLEGAL) begin
          state_next    = ERROR;
          link_err_next = 1'b1;
        end else if (!ready_f && (result_f == RES_NONE)) begin
          state_next = IDLE;
        end else if (tcnt == TMAX) begin
          state_next   = ERROR;
          timeout_next = 1'b1;
        end
      end
      GOT: begin
        if (result_f == RES_NONE) begin
          state_next = ready_f ? PEER_READY : IDLE;
        end
      end
      ERROR: begin
        if (clr) begin
          state_next    = IDLE;
          link_err_next = 1'b0;
          timeout_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, registered outputs and the timeout counter. The counter only
  // runs while staying in PEER_READY, so every entry starts from zero, and
  // it sticks at its last value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ready_f_q    <= 1'b0;
      tcnt         <= '0;
      ready_2p     <= 1'b0;
      ready_rise   <= 1'b0;
      result       <= RES_NONE;
      result_valid <= 1'b0;
      link_err     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_next;
      ready_f_q    <= ready_f;
      ready_2p     <= ready_f;
      ready_rise   <= rise_next;
      result       <= result_next;
      result_valid <= valid_next;
      link_err     <= link_err_next;
      timeout      <= timeout_next;
      if ((state == PEER_READY) && (state_next == PEER_READY)) begin
        tcnt <= (tcnt == TMAX) ? tcnt : tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_link_rx.sv
// Directed self-checking bench for link_rx with STABLE_CYC=4 and
// TIMEOUT_CYC=100. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so "edge N" below means N rising edges after
// the input change. A raw change shows up on the filtered value at edge 6
// and on the registered outputs at edge 7.
module tb_link_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready_in;
  logic [1:0] result_in;
  logic       clr;
  logic       ready_2p;
  logic       ready_rise;
  logic [1:0] result;
  logic       result_valid;
  logic       link_err;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  link_rx #(
    .STABLE_CYC (4),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ready_in    (ready_in),
    .result_in   (result_in),
    .clr         (clr),
    .ready_2p    (ready_2p),
    .ready_rise  (ready_rise),
    .result      (result),
    .result_valid(result_valid),
    .link_err    (link_err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_in = 1'b0; result_in = 2'b00; clr = 1'b0;
    tick(3);
    checks++; if (ready_2p !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_2p got %b want 0", ready_2p); end
    checks++; if (ready_rise !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_rise got %b want 0", ready_rise); end
    checks++; if (result !== 2'b00) begin errors++; $display("[TB] FAIL reset_result got %b want 00", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_result_valid got %b want 0", result_valid); end
    checks++; if (link_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_link_err got %b want 0", link_err); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b want 0", timeout); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_ready_rise();
    ready_in = 1'b1;
    tick(6);
    checks++; if (ready_2p !== 1'b0) begin errors++; $display("[TB] FAIL rise_early_ready_2p got %b want 0", ready_2p); end
    checks++; if (ready_rise !== 1'b0) begin errors++; $display("[TB] FAIL rise_early_pulse got %b want 0", ready_rise); end
    tick(1);
    checks++; if (ready_2p !== 1'b1) begin errors++; $display("[TB] FAIL rise_ready_2p got %b want 1", ready_2p); end
    checks++; if (ready_rise !== 1'b1) begin errors++; $display("[TB] FAIL rise_pulse got %b want 1", ready_rise); end
    tick(1);
    checks++; if (ready_rise !== 1'b0) begin errors++; $display("[TB] FAIL rise_pulse_width got %b want 0", ready_rise); end
    checks++; if (ready_2p !== 1'b1) begin errors++; $display("[TB] FAIL rise_level_held got %b want 1", ready_2p); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    result_in = 2'b01;
    tick(3);
    result_in = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (result_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL glitch_pulses got %0d want 0", pulses); end
    checks++; if (result !== 2'b00) begin errors++; $display("[TB] FAIL glitch_result got %b want 00", result); end
  endtask

  task automatic test_result_capture();
    int pulses = 0;
    result_in = 2'b10;
    tick(6);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL cap1_early_valid got %b want 0", result_valid); end
    tick(1);
    checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL cap1_valid got %b want 1", result_valid); end
    checks++; if (result !== 2'b10) begin errors++; $display("[TB] FAIL cap1_result got %b want 10", result); end
    for (int i = 0; i < 13; i++) begin
      tick(1);
      if (result_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL cap1_extra_pulses got %0d want 0", pulses); end
    result_in = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (result_valid === 1'b1) pulses++;
    end
    checks++; if (result !== 2'b10) begin errors++; $display("[TB] FAIL cap1_held got %b want 10", result); end
    result_in = 2'b01;
    tick(6);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL cap2_early_valid got %b want 0", result_valid); end
    tick(1);
    checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL cap2_valid got %b want 1", result_valid); end
    checks++; if (result !== 2'b01) begin errors++; $display("[TB] FAIL cap2_result got %b want 01", result); end
    for (int i = 0; i < 13; i++) begin
      tick(1);
      if (result_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL cap2_extra_pulses got %0d want 0", pulses); end
    result_in = 2'b00;
    tick(10);
  endtask

  task automatic test_ready_fall();
    int pulses = 0;
    ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (result_valid === 1'b1 || ready_rise === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL fall_pulses got %0d want 0", pulses); end
    checks++; if (ready_2p !== 1'b0) begin errors++; $display("[TB] FAIL fall_ready_2p got %b want 0", ready_2p); end
    ready_in = 1'b1;
    tick(7);
    checks++; if (ready_rise !== 1'b1) begin errors++; $display("[TB] FAIL fall_rerise_pulse got %b want 1", ready_rise); end
  endtask

  // Entered PEER_READY on the edge just sampled, so the timeout lands
  // exactly 100 edges later.
  task automatic test_timeout();
    int pulses = 0;
    tick(99);
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early got %b want 0", timeout); end
    tick(1);
    checks++; if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_set got %b want 1", timeout); end
    checks++; if (link_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_link_err got %b want 0", link_err); end
    tick(5);
    checks++; if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky got %b want 1", timeout); end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clr got %b want 0", timeout); end
    result_in = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (result_valid === 1'b1 || ready_rise === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL timeout_idle_pulses got %0d want 0", pulses); end
    checks++; if (result !== 2'b01) begin errors++; $display("[TB] FAIL timeout_idle_result got %b want 01", result); end
    result_in = 2'b00;
    tick(10);
  endtask

  task automatic test_link_err();
    ready_in = 1'b0;
    tick(10);
    ready_in = 1'b1;
    tick(7);
    checks++; if (ready_rise !== 1'b1) begin errors++; $display("[TB] FAIL err_rise got %b want 1", ready_rise); end
    result_in = 2'b11;
    tick(6);
    checks++; if (link_err !== 1'b0) begin errors++; $display("[TB] FAIL err_early got %b want 0", link_err); end
    tick(1);
    checks++; if (link_err !== 1'b1) begin errors++; $display("[TB] FAIL err_set got %b want 1", link_err); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_no_valid got %b want 0", result_valid); end
    checks++; if (result !== 2'b01) begin errors++; $display("[TB] FAIL err_result_kept got %b want 01", result); end
    tick(5);
    checks++; if (link_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b want 1", link_err); end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++; if (link_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clr got %b want 0", link_err); end
    tick(10);
    checks++; if (link_err !== 1'b0) begin errors++; $display("[TB] FAIL err_idle_ignores got %b want 0", link_err); end
    result_in = 2'b00;
    tick(10);
  endtask

  task automatic test_simultaneous();
    ready_in = 1'b0;
    tick(10);
    ready_in = 1'b1;
    tick(7);
    checks++; if (ready_rise !== 1'b1) begin errors++; $display("[TB] FAIL sim_rise got %b want 1", ready_rise); end
    result_in = 2'b10;
    ready_in  = 1'b0;
    tick(7);
    checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL sim_valid got %b want 1", result_valid); end
    checks++; if (result !== 2'b10) begin errors++; $display("[TB] FAIL sim_result got %b want 10", result); end
    checks++; if (ready_2p !== 1'b0) begin errors++; $display("[TB] FAIL sim_ready_2p got %b want 0", ready_2p); end
    result_in = 2'b00;
    tick(10);
    ready_in = 1'b1;
    tick(7);
    checks++; if (ready_rise !== 1'b1) begin errors++; $display("[TB] FAIL sim_back_to_idle got %b want 1", ready_rise); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    result_in = 2'b01;
    tick(4);
    rst = 1'b1;
    ready_in = 1'b0;
    tick(1);
    rst = 1'b0;
    checks++; if (result !== 2'b00) begin errors++; $display("[TB] FAIL rmid_result got %b want 00", result); end
    checks++; if (ready_2p !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ready_2p got %b want 0", ready_2p); end
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (result_valid === 1'b1 || ready_rise === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL rmid_pulses got %0d want 0", pulses); end
    checks++; if (result !== 2'b00) begin errors++; $display("[TB] FAIL rmid_result_after got %b want 00", result); end
    checks++; if ({link_err, timeout} !== 2'b00) begin errors++; $display("[TB] FAIL rmid_flags got %b want 00", {link_err, timeout}); end
  endtask

  initial begin
    test_reset();
    test_ready_rise();
    test_glitch();
    test_result_capture();
    test_ready_fall();
    test_timeout();
    test_link_err();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
